// File: rtl/adc_deserializer_pkg.sv
// Shared definitions for the ADC capture path and the downstream accumulator:
// sample width, bit-counter width, FSM encoding and a shift helper.
package adc_deserializer_pkg;

  localparam int SAMPLE_W = 16;
  localparam int CNT_W    = $clog2(SAMPLE_W) + 1;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } deser_state_e;

  // MSB-first serial data: older bits move toward the MSB.
  function automatic sample_t shift_in(input sample_t word, input logic bit_in);
    return {word[SAMPLE_W-2:0], bit_in};
  endfunction

endpackage

// File: rtl/adc_deserializer_sync_ff.sv
// Single-bit multi-flop synchronizer for signals crossing into the clk domain.
// All stages clear on reset so no stale level is seen after reset release.
module sync_ff #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sync_q;
  logic [DEPTH-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[DEPTH-2:0], d};
  end

  // NOTE: state flops use non-blocking assignments so every stage samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[DEPTH-1];

endmodule

// File: rtl/adc_deserializer.sv
// Captures one channel of an I2S-style ADC stream into 16-bit samples, with a
// one-cycle valid strobe and a frame-error strobe for short frames.
module adc_deserializer
  import adc_deserializer_pkg::*;
#(
  parameter int CHANNEL     = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                adc_bclk,
  input  logic                adc_lrck,
  input  logic                adc_sdata,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_valid,
  output logic                frame_err
);

  localparam logic             SEL_LEVEL = (CHANNEL != 0);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(SAMPLE_W - 1);

  logic bclk_s;
  logic lrck_s;
  logic sdata_s;

  sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_bclk (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (adc_bclk),
    .q       (bclk_s)
  );

  sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_lrck (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (adc_lrck),
    .q       (lrck_s)
  );

  sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_sdata (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (adc_sdata),
    .q       (sdata_s)
  );

  logic         bclk_prev_q, bclk_prev_d;
  logic         lrck_prev_q, lrck_prev_d;
  logic         bclk_rise;
  logic         lrck_edge;
  logic         lrck_match;

  deser_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  sample_t          shift_q, shift_d;
  sample_t          sample_q, sample_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  sample_t          shift_next;

  // lrck is only looked at on bit-clock rises, so a word-select change is
  // seen on the same bit slot the ADC uses to start the new frame.
  always_comb begin
    bclk_rise   = bclk_s & ~bclk_prev_q;
    lrck_edge   = bclk_rise & (lrck_s ^ lrck_prev_q);
    lrck_match  = (lrck_s == SEL_LEVEL);
    bclk_prev_d = bclk_s;
    lrck_prev_d = bclk_rise ? lrck_s : lrck_prev_q;
    shift_next  = shift_in(shift_q, sdata_s);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves a signal unassigned and a latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (lrck_edge && lrck_match) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (lrck_edge) begin
          state_d = ST_IDLE;
        end else if (bclk_rise && (cnt_q == LAST_BIT)) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (lrck_edge) state_d = lrck_match ? ST_SHIFT : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_HOLD: begin
        // The edge that opens a frame carries no data bit of this word.
        if (lrck_edge && lrck_match) begin
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      ST_SHIFT: begin
        if (lrck_edge) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          shift_d = '0;
        end else if (bclk_rise) begin
          shift_d = shift_next;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            sample_d = shift_next;
            valid_d  = 1'b1;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        shift_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_prev_q <= 1'b0;
      lrck_prev_q <= 1'b0;
      cnt_q       <= '0;
      shift_q     <= '0;
      sample_q    <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      bclk_prev_q <= bclk_prev_d;
      lrck_prev_q <= lrck_prev_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      sample_q    <= sample_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign frame_err    = err_q;

endmodule
